mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped byte sink for the processor's store path; serialises bytes to an 8N1 UART line.
//  A store to the IO address presents write_enabled/write_value. The byte is queued in a FIFO
//  and shifted out LSB-first.
//  When the FIFO is full, clk_stall is raised so the processor freezes its pipeline
//  (gated clock) and holds the store until a slot frees.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; legal >= 2
//  FIFO_DEPTH    4   queued bytes; power of 2, >= 2
// PORTS
//  clk           in   1    the only clock; everything is updated on posedge clk
//  reset         in   1    synchronous, active-high
//  write_enabled in   1    store to IO address this cycle; held while clk_stall=1
//  write_value   in   8    byte to transmit
//  clk_stall     out  1    combinational: write_enabled && fifo_full
//  tx            out  1    serial line, registered, idle high
//  busy          out  1    frame in progress (state != IDLE)
//  fifo_full     out  1    count == FIFO_DEPTH
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte on the wire
// BEHAVIOUR
//  Reset (synchronous, at posedge with reset=1):
//   - Outputs: tx=1, busy=0, fifo_full=0, fifo_count=0.
//   - Internal: state=IDLE, read and write pointers=0, bit and baud counters=0.
//   - clk_stall=0 follows combinationally from fifo_full=0.
//   - Reset mid-frame aborts the frame: tx returns high the next cycle and queued bytes are discarded.
//  Push:
//   - At a posedge with write_enabled=1 and fifo_full=0, write_value is stored and the count increments.
//   - With fifo_full=1 nothing is stored and clk_stall=1; the byte is accepted at the first edge where full is low.
//  Pop: occurs when state is IDLE, or on the last cycle of STOP, and count>0.
//  Simultaneous push and pop: the count is unchanged and both pointers advance.
//  A push to an empty FIFO cannot be popped in the same cycle; the pop is one edge later.
//  Pointers wrap modulo FIFO_DEPTH. Count saturates by construction: no push when full, no pop when empty.
//  FSM (the baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state):
//   - IDLE:  tx=1. If count>0: pop into the shift register, go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   - DATA:  tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
//            After bit 7 go to PARITY if enabled, else STOP.
//   - PARITY: only when parity is enabled; see CONFIGURATION.
//   - STOP:  tx=1 for CLKS_PER_BIT cycles. On the final cycle: if count>0, pop and go to START
//            (back-to-back, no idle gap); otherwise go to IDLE.
//  Latency: a write accepted at edge E into an empty, idle block pops at E+1; tx falls after E+1.
//  Frame length is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
//  tx is glitch-free: it is driven only from the state register and the shift register.
// CONFIGURATION
//  MMIO_UART_TX_PARITY_EN defined:
//   - PARITY state is inserted after DATA: tx = ^byte (even parity) for CLKS_PER_BIT cycles.
//   - The parity value is latched at pop time.
//  Undefined: no PARITY state, 8N1 framing only; the parity logic must not be synthesised.
// TESTING
//  1. Reset, then hold 20 cycles -> tx=1, busy=0, fifo_count=0, clk_stall=0 throughout.
//  2. CLKS_PER_BIT=4, write 8'hA5 at edge E -> tx low on cycles E+1..E+4.
//     Then data bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high. busy=0 after 40 cycles.
//  3. Write 8'h01 then 8'h80 on consecutive edges -> second START begins the cycle after
//     the first STOP ends; tx never idles between the frames.
//  4. FIFO_DEPTH=4: write 6 bytes back-to-back -> the 6th write sees clk_stall=1 until the
//     first STOP completes. It is then accepted, and all 6 bytes appear on tx in order.
//  5. Assert reset mid-DATA of 8'hFF with 2 bytes queued -> tx=1 the next cycle, count=0.
//     Nothing further is transmitted.
//  6. With MMIO_UART_TX_PARITY_EN, send 8'h07 -> the parity bit is 1 and the frame is 11 bit-times.
//     8'h03 gives a parity bit of 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO store sink that queues bytes and shifts them out as 8N1 UART (8E1 with MMIO_UART_TX_PARITY_EN).
// Latency: a byte accepted into an empty idle block pops one edge later; tx falls on that same edge.
// Backpressure: clk_stall = write_enabled && fifo_full; the store is held until a slot frees.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_enabled,
    input  logic [7:0]                    write_value,
    output logic                          clk_stall,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          baud_last;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    pop_dat;
    logic          tx_next;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (write_enabled),
        .push_dat (write_value),
        .pop      (fifo_pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign clk_stall = write_enabled && fifo_full;
    assign busy      = (state != IDLE);
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (baud_last) state_next = DATA;
            DATA: begin
                if (baud_last && bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: if (baud_last) state_next = STOP;
`endif
            STOP: begin
                // Back-to-back frames: the next START follows the final stop cycle directly.
                if (baud_last) state_next = fifo_empty ? IDLE : START;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = !fifo_empty && ((state == IDLE) || (state == STOP && baud_last));
        tx_next  = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        shift_next = shift;
        if (fifo_pop)                     shift_next = pop_dat;
        else if (state == DATA && baud_last) shift_next = {1'b0, shift[7:1]};
    end

    // tx is registered from next-state values so it changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            tx    <= tx_next;
            shift <= shift_next;
            if (state == IDLE || baud_last) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;
            if (state != DATA)   bit_idx <= '0;
            else if (baud_last)  bit_idx <= bit_idx + 1'b1;
        end
    end

`ifdef MMIO_UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)         parity_bit <= 1'b0;
        else if (fifo_pop) parity_bit <= ^pop_dat;
    end
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: fixed frame table, back-to-back, stall, random traffic and mid-frame reset.
// A line receiver decodes tx into bytes which are compared against the queue of accepted stores.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       write_enabled;
    logic [7:0] write_value;
    logic       clk_stall;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enabled (write_enabled),
        .write_value   (write_value),
        .clk_stall     (clk_stall),
        .tx            (tx),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_start[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, data[7:0], start}, bit 0 goes first
        logic       par;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int j);
        if (j < 9) return v.frame[j];
`ifdef MMIO_UART_TX_PARITY_EN
        if (j == 9) return v.par;
`endif
        return 1'b1;
    endfunction

    // Present a store and hold it through any stall; returns at the negedge after acceptance.
    task automatic push(input logic [7:0] b, output int edge_no, output int stalls);
        stalls = 0;
        write_enabled = 1'b1;
        write_value   = b;
        #1;
        while (clk_stall && stalls < 500) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (stalls >= 500) check("push_stall_timeout", 1, 0);
        @(negedge clk);
        edge_no = cyc;
        write_enabled = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || fifo_count != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n >= 3000), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_compare(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rx_q.size() == 0) check({name, "_missing"}, 32'hFFFF_FFFF, e);
            else                  check(name, rx_q.pop_front(), e);
        end
        check({name, "_extra"}, rx_q.size(), 0);
    endtask

    // Line receiver: samples each bit mid-period after seeing the start edge.
    initial begin
        logic [7:0] b;
        int st;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                st = cyc;
                repeat (CPB/2) @(negedge clk);
                check("mon_start", tx, 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
`ifdef MMIO_UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                check("mon_parity", tx, ^b);
`endif
                repeat (CPB) @(negedge clk);
                check("mon_stop", tx, 1);
                rx_q.push_back(b);
                rx_start.push_back(st);
            end
        end
    end

    initial begin
        int e, s, e0, e4, e5, s5;
        logic [7:0] rb;

        tbl[0] = '{8'hA5, 10'h34A, 1'b0};
        tbl[1] = '{8'h00, 10'h200, 1'b0};
        tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
        tbl[3] = '{8'h01, 10'h202, 1'b1};
        tbl[4] = '{8'h80, 10'h300, 1'b1};
        tbl[5] = '{8'h3C, 10'h278, 1'b0};
        tbl[6] = '{8'h07, 10'h20E, 1'b1};
        tbl[7] = '{8'h03, 10'h206, 1'b0};

        reset = 1'b1;
        write_enabled = 1'b0;
        write_value = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_count", fifo_count, 0);
            check("rst_stall", clk_stall, 0);
        end

        for (int i = 0; i < 8; i++) begin
            push(tbl[i].data, e, s);
            check("tbl_latency", tx, 1);
            @(negedge clk);
            check("tbl_fall", tx, 0);
            check("tbl_busy", busy, 1);
            repeat (CPB/2) @(negedge clk);
            for (int j = 0; j < NB; j++) begin
                if (j > 0) repeat (CPB) @(negedge clk);
                check($sformatf("tbl%0d_bit%0d", i, j), tx, exp_bit(tbl[i], j));
            end
            while (cyc < e + NB*CPB) @(negedge clk);
            check("tbl_busy_end", busy, 1);
            @(negedge clk);
            check("tbl_busy_clear", busy, 0);
        end

        mon_en = 1'b1;
        rx_start.delete();
        push(8'h01, e0, s); exp_q.push_back(8'h01);
        push(8'h80, e, s);  exp_q.push_back(8'h80);
        check("b2b_edges", e, e0 + 1);
        wait_idle();
        if (rx_start.size() >= 2) begin
            check("b2b_first_start", rx_start[0], e0 + 1);
            check("b2b_gap", rx_start[1] - rx_start[0], NB*CPB);
        end else begin
            check("b2b_frames", rx_start.size(), 2);
        end
        drain_compare("b2b_byte");

        for (int i = 0; i < 5; i++) begin
            rb = 8'h10 + 8'(i);
            push(rb, e, s);
            exp_q.push_back(rb);
            check("fill_nostall", s, 0);
            if (i == 0) e0 = e;
            if (i == 4) e4 = e;
        end
        check("fill_count", fifo_count, DEPTH);
        check("fill_full", fifo_full, 1);
        push(8'h15, e5, s5);
        exp_q.push_back(8'h15);
        check("stall_accept_edge", e5, e0 + 1 + NB*CPB + 1);
        check("stall_cycles", s5, e5 - e4 - 1);
        wait_idle();
        drain_compare("stall_byte");

        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            push(rb, e, s);
            exp_q.push_back(rb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_idle();
        drain_compare("rand_byte");

        mon_en = 1'b0;
        push(8'hFF, e, s);
        push(8'h11, e0, s);
        push(8'h22, e0, s);
        while (cyc < e + 1 + CPB + 2*CPB + 1) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_count", fifo_count, 2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_tx", tx, 1);
        check("mid_reset_count", fifo_count, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_full", fifo_full, 0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("post_reset_tx", tx, 1);
            check("post_reset_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
